alu_entry_ctrl: RTL and testbench

ALU_ENTRY_CTRL -- requirements
Module: alu_entry_ctrl

---
 rtl/alu_entry_ctrl.sv | 164 ++++++++++++++++
 tb/tb_alu_entry_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_entry_ctrl.sv
// Operand-entry controller for a switch/button driven ALU front panel.
// The user walks through A -> B -> OP with the "enter" button, launches
// the ALU, waits for completion (or a timeout) and then views the result.
// Handshake: alu_start is a one-cycle launch strobe; alu_done is a
// one-cycle completion strobe that only counts while in S_EXEC.
module alu_entry_ctrl #(
   parameter int WIDTH   = 8,
   parameter int LOCKOUT = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             next_pulse,
   input  logic             back_pulse,
   input  logic [WIDTH-1:0] sw,
   input  logic             alu_done,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic [2:0]       opcode,
   output logic             alu_start,
   output logic [2:0]       phase,
   output logic             result_valid,
   output logic             error
);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_SHOW = 3'd4
   } state_t;

   localparam int          LW      = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [2:0]       opcode_q, opcode_d;
   logic             alu_start_q, alu_start_d;
   logic             result_valid_q, result_valid_d;
   logic             error_q, error_d;
   logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
   logic [15:0]      to_cnt_q, to_cnt_d;

   logic             press;
   logic             accept;
   logic             is_back;

   // Press qualification, lockout countdown and the entry/exec state machine.
   always_comb begin
      state_d        = state_q;
      op_a_d         = op_a_q;
      op_b_d         = op_b_q;
      opcode_d       = opcode_q;
      alu_start_d    = 1'b0;
      result_valid_d = result_valid_q;
      error_d        = error_q;
      lock_cnt_d     = lock_cnt_q;
      to_cnt_d       = to_cnt_q;

      // Back wins when both buttons fire together.
      press   = next_pulse | back_pulse;
      is_back = back_pulse;
      // Presses while the ALU runs are dropped and never arm the lockout.
      accept  = press && (lock_cnt_q == '0) && (state_q != S_EXEC);

      if (accept) begin
         lock_cnt_d = LW'(LOCKOUT);
      end else if (lock_cnt_q != '0) begin
         lock_cnt_d = lock_cnt_q - 1'b1;
      end

      case (state_q)
         S_A: begin
            if (accept && !is_back) begin
               op_a_d  = sw;
               state_d = S_B;
            end
         end
         S_B: begin
            if (accept) begin
               if (is_back) begin
                  state_d = S_A;
               end else begin
                  op_b_d  = sw;
                  state_d = S_OP;
               end
            end
         end
         S_OP: begin
            if (accept) begin
               if (is_back) begin
                  state_d = S_B;
               end else begin
                  opcode_d    = sw[2:0];
                  alu_start_d = 1'b1;
                  to_cnt_d    = '0;
                  state_d     = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            // A done strobe on the final allowed cycle still counts as success.
            if (alu_done) begin
               result_valid_d = 1'b1;
               error_d        = 1'b0;
               state_d        = S_SHOW;
            end else if (to_cnt_q == TO_LAST) begin
               result_valid_d = 1'b0;
               error_d        = 1'b1;
               state_d        = S_SHOW;
            end else begin
               to_cnt_d = to_cnt_q + 16'd1;
            end
         end
         S_SHOW: begin
            if (accept) begin
               result_valid_d = 1'b0;
               error_d        = 1'b0;
               state_d        = S_A;
            end
         end
         default: begin
            state_d = S_A;
         end
      endcase
   end

   // State and output registers with asynchronous active-low clear.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q        <= S_A;
         op_a_q         <= '0;
         op_b_q         <= '0;
         opcode_q       <= '0;
         alu_start_q    <= 1'b0;
         result_valid_q <= 1'b0;
         error_q        <= 1'b0;
         lock_cnt_q     <= '0;
         to_cnt_q       <= '0;
      end else begin
         state_q        <= state_d;
         op_a_q         <= op_a_d;
         op_b_q         <= op_b_d;
         opcode_q       <= opcode_d;
         alu_start_q    <= alu_start_d;
         result_valid_q <= result_valid_d;
         error_q        <= error_d;
         lock_cnt_q     <= lock_cnt_d;
         to_cnt_q       <= to_cnt_d;
      end
   end

   assign op_a         = op_a_q;
   assign op_b         = op_b_q;
   assign opcode       = opcode_q;
   assign alu_start    = alu_start_q;
   assign phase        = state_q;
   assign result_valid = result_valid_q;
   assign error        = error_q;

endmodule

// File: tb/tb_alu_entry_ctrl.sv
// Directed bench for alu_entry_ctrl (WIDTH=8, LOCKOUT=4, TIMEOUT=10).
// Expected operand/opcode triples are queued when a launching press is
// driven and popped when the DUT raises alu_start.
module tb_alu_entry_ctrl;

   localparam int WIDTH   = 8;
   localparam int LOCKOUT = 4;
   localparam int TIMEOUT = 10;

   logic             clock;
   logic             rst;
   logic             next_pulse;
   logic             back_pulse;
   logic [WIDTH-1:0] sw;
   logic             alu_done;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [2:0]       opcode;
   logic             alu_start;
   logic [2:0]       phase;
   logic             result_valid;
   logic             error;

   int compared   = 0;
   int mismatched = 0;

   logic [2*WIDTH+2:0] exp_q[$];

   alu_entry_ctrl #(
      .WIDTH  (WIDTH),
      .LOCKOUT(LOCKOUT),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clock       (clock),
      .rst         (rst),
      .next_pulse  (next_pulse),
      .back_pulse  (back_pulse),
      .sw          (sw),
      .alu_done    (alu_done),
      .op_a        (op_a),
      .op_b        (op_b),
      .opcode      (opcode),
      .alu_start   (alu_start),
      .phase       (phase),
      .result_valid(result_valid),
      .error       (error)
   );

   // Clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One-cycle press; returns one step after the sampling edge.
   task automatic press(input logic n, input logic b, input logic [WIDTH-1:0] v);
      sw         = v;
      next_pulse = n;
      back_pulse = b;
      tick();
      next_pulse = 1'b0;
      back_pulse = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_phase"},  32'(phase), 0);
      check({tag, "_op_a"},   32'(op_a), 0);
      check({tag, "_op_b"},   32'(op_b), 0);
      check({tag, "_opcode"}, 32'(opcode), 0);
      check({tag, "_start"},  32'(alu_start), 0);
      check({tag, "_valid"},  32'(result_valid), 0);
      check({tag, "_error"},  32'(error), 0);
   endtask

   // Scoreboard: each alu_start cycle must match the oldest queued launch.
   always @(negedge clock) begin
      if (alu_start === 1'b1) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL launch_unexpected: observed %0h expected none", {op_a, op_b, opcode});
         end else begin
            logic [2*WIDTH+2:0] e;
            e = exp_q.pop_front();
            compared++;
            assert ({op_a, op_b, opcode} === e) else begin
               mismatched++;
               $error("FAIL launch_operands: observed %0h expected %0h", {op_a, op_b, opcode}, e);
            end
         end
      end
   end

   initial begin
      rst        = 1'b0;
      next_pulse = 1'b0;
      back_pulse = 1'b0;
      sw         = '0;
      alu_done   = 1'b0;

      // Reset state
      #2;
      check_all_zero("rst_init");
      tick();
      #2;
      rst = 1'b1;

      // Entry: first press lands on the first edge after release
      press(1, 0, 8'h3C);
      check("entry_a_phase", 32'(phase), 1);
      check("entry_a_val",   32'(op_a), 32'h3C);
      repeat (5) tick();
      press(1, 0, 8'h05);
      check("entry_b_phase", 32'(phase), 2);
      check("entry_b_val",   32'(op_b), 32'h05);
      repeat (5) tick();
      exp_q.push_back({8'h3C, 8'h05, 3'd2});
      press(1, 0, 8'h02);
      check("entry_op_phase", 32'(phase), 3);
      check("entry_op_val",   32'(opcode), 2);
      check("entry_start_hi", 32'(alu_start), 1);
      tick();
      check("entry_start_lo", 32'(alu_start), 0);
      check("exec_hold",      32'(phase), 3);

      // Success: done 3 cycles after alu_start
      tick();
      tick();
      alu_done = 1'b1;
      tick();
      alu_done = 1'b0;
      check("ok_phase", 32'(phase), 4);
      check("ok_valid", 32'(result_valid), 1);
      check("ok_error", 32'(error), 0);
      repeat (5) tick();
      press(1, 0, 8'hFF);
      check("show_next_phase", 32'(phase), 0);
      check("show_next_valid", 32'(result_valid), 0);
      check("show_next_op_a",  32'(op_a), 32'h3C);

      // Lockout: t accepted, t+2 blocked, t+5 accepted
      repeat (5) tick();
      press(1, 0, 8'h21);
      check("lock_t_phase", 32'(phase), 1);
      check("lock_t_op_a",  32'(op_a), 32'h21);
      tick();
      press(1, 0, 8'h99);
      check("lock_t2_phase", 32'(phase), 1);
      check("lock_t2_op_b",  32'(op_b), 32'h05);
      tick();
      tick();
      press(1, 0, 8'h44);
      check("lock_t5_phase", 32'(phase), 2);
      check("lock_t5_op_b",  32'(op_b), 32'h44);

      // Back priority in S_OP
      repeat (5) tick();
      press(1, 1, 8'h07);
      check("both_phase",  32'(phase), 1);
      check("both_opcode", 32'(opcode), 2);
      check("both_op_b",   32'(op_b), 32'h44);

      // Timeout with no done
      repeat (5) tick();
      press(1, 0, 8'h05);
      repeat (5) tick();
      exp_q.push_back({8'h21, 8'h05, 3'd3});
      press(1, 0, 8'h03);
      check("to_enter", 32'(phase), 3);
      repeat (9) tick();
      check("to_last_cycle_phase", 32'(phase), 3);
      check("to_last_cycle_error", 32'(error), 0);
      tick();
      check("to_phase", 32'(phase), 4);
      check("to_error", 32'(error), 1);
      check("to_valid", 32'(result_valid), 0);
      press(1, 0, 8'h00);
      check("to_clear_phase", 32'(phase), 0);
      check("to_clear_error", 32'(error), 0);

      // Done coincident with the final cycle wins
      repeat (5) tick();
      press(1, 0, 8'h0A);
      repeat (5) tick();
      press(1, 0, 8'h0B);
      repeat (5) tick();
      exp_q.push_back({8'h0A, 8'h0B, 3'd1});
      press(1, 0, 8'h01);
      repeat (9) tick();
      check("edge_last_phase", 32'(phase), 3);
      alu_done = 1'b1;
      tick();
      alu_done = 1'b0;
      check("edge_phase", 32'(phase), 4);
      check("edge_valid", 32'(result_valid), 1);
      check("edge_error", 32'(error), 0);

      // Done outside S_EXEC is ignored
      alu_done = 1'b1;
      tick();
      alu_done = 1'b0;
      check("stray_done_phase", 32'(phase), 4);
      check("stray_done_valid", 32'(result_valid), 1);

      // Back from S_SHOW, then back in S_A still arms the lockout
      repeat (5) tick();
      press(0, 1, 8'h00);
      check("show_back_phase", 32'(phase), 0);
      check("show_back_valid", 32'(result_valid), 0);
      check("show_back_op_a",  32'(op_a), 32'h0A);
      repeat (5) tick();
      press(0, 1, 8'h00);
      check("a_back_phase", 32'(phase), 0);
      press(1, 0, 8'h77);
      check("a_back_lock_phase", 32'(phase), 0);
      check("a_back_lock_op_a",  32'(op_a), 32'h0A);
      tick();
      tick();
      tick();
      press(1, 0, 8'h31);
      check("a_back_after_phase", 32'(phase), 1);
      check("a_back_after_op_a",  32'(op_a), 32'h31);

      // Reset in the middle of S_EXEC
      repeat (5) tick();
      press(1, 0, 8'h32);
      repeat (5) tick();
      exp_q.push_back({8'h31, 8'h32, 3'd4});
      press(1, 0, 8'h04);
      check("mid_exec_phase", 32'(phase), 3);
      #5;
      rst = 1'b0;
      #1;
      check_all_zero("rst_mid");
      tick();
      #2;
      rst      = 1'b1;
      alu_done = 1'b1;
      tick();
      alu_done = 1'b0;
      check("post_rst_done_phase", 32'(phase), 0);
      check("post_rst_done_valid", 32'(result_valid), 0);
      press(1, 0, 8'h55);
      check("post_rst_press_phase", 32'(phase), 1);
      check("post_rst_press_op_a",  32'(op_a), 32'h55);

      tick();
      check("launch_queue_drained", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
